// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
// Multi-cycle interpreter for a small MIPS-I integer subset
// (add/sub/and/or/slt, addi, lw, sw, beq, halt). Each instruction walks
// FETCH -> DECODE -> EXEC [-> MEM] [-> WB]. The data memory is mapped at
// byte address DMEM_BASE.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ld_we/ld_sel/     load port: write imem (sel=0) or dmem (sel=1) word
//   ld_addr/ld_wdata    ld_addr; ignored while busy, out-of-range dropped
//   prog_len          number of valid instructions, sampled on start
//   start             run request, honoured only in IDLE or HALT
//   busy              high in FETCH..WB
//   done, err         sticky status, cleared by the next accepted start
//   retire/retire_pc  one-cycle pulse (and word PC) per completed instr
//   dbg_reg_*         combinational register-file read ($0 reads 0)
//   dbg_mem_*         combinational data-memory read
module mips_multicycle_core #(
  parameter int                DATA_W     = 32,
  parameter int                IMEM_DEPTH = 16,
  parameter int                DMEM_DEPTH = 32,
  parameter logic [DATA_W-1:0] DMEM_BASE  = 32'h0000_4000,
  localparam int LA_W = $clog2(IMEM_DEPTH > DMEM_DEPTH ? IMEM_DEPTH : DMEM_DEPTH),
  localparam int PC_W = $clog2(IMEM_DEPTH),
  localparam int PL_W = PC_W + 1,
  localparam int DA_W = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [LA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [PL_W-1:0]   prog_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              retire,
  output logic [PC_W-1:0]   retire_pc,
  input  logic [4:0]        dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data,
  input  logic [DA_W-1:0]   dbg_mem_addr,
  output logic [DATA_W-1:0] dbg_mem_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [2:0]        state;
  logic [PL_W-1:0]   pc, plen;
  logic [31:0]       ir;
  logic [DATA_W-1:0] opa, opb, simm, res;
  logic [DATA_W-1:0] rf   [32];
  logic [DATA_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  // instruction fields, all taken from the latched ir
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, wb_dst;
  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign fn     = ir[5:0];
  assign wb_dst = (op == OP_R) ? rd : rt;

  logic unused_shamt;
  assign unused_shamt = ^ir[10:6];

  // ALU: R-type ops, otherwise base + sign-extended immediate
  logic [DATA_W-1:0] alu;
  logic              r_ok, exec_ok;
  always_comb begin
    alu  = opa + simm;
    r_ok = 1'b1;
    if (op == OP_R) begin
      case (fn)
        F_ADD:   alu = opa + opb;
        F_SUB:   alu = opa - opb;
        F_AND:   alu = opa & opb;
        F_OR:    alu = opa | opb;
        F_SLT:   alu = {{(DATA_W-1){1'b0}}, $signed(opa) < $signed(opb)};
        default: r_ok = 1'b0;
      endcase
    end
  end

  assign exec_ok = (op == OP_R) ? r_ok :
                   (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
                   (op == OP_BEQ)  || (op == OP_HALT);

  // effective address (held in res during MEM) -> word index + range check
  logic [DATA_W-1:0] ea_off;
  logic [DA_W-1:0]   mem_idx;
  logic              mem_bad;
  assign ea_off  = res - DMEM_BASE;
  assign mem_idx = ea_off[DA_W+1:2];
  assign mem_bad = (res[1:0] != 2'b00) || (res < DMEM_BASE) ||
                   ((ea_off >> 2) >= DATA_W'(DMEM_DEPTH));

  // PC math is one bit wider than the imem index so out-of-range targets
  // compare as such instead of wrapping back into the program
  logic [PL_W-1:0] pc_inc, br_tgt;
  assign pc_inc = pc + PL_W'(1);
  assign br_tgt = pc_inc + simm[PL_W-1:0];

  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign retire    = (state == S_WB) ||
                     ((state == S_MEM)  && (op == OP_SW) && !mem_bad) ||
                     ((state == S_EXEC) && ((op == OP_BEQ) || (op == OP_HALT)));
  assign retire_pc = pc[PC_W-1:0];

  assign dbg_reg_data = rf[dbg_reg_addr];
  assign dbg_mem_data = dmem[dbg_mem_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      plen  <= '0;
      ir    <= '0;
      opa   <= '0;
      opb   <= '0;
      simm  <= '0;
      res   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            plen  <= prog_len;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (pc >= plen || pc >= PL_W'(IMEM_DEPTH)) begin
            state <= S_HALT;
            done  <= 1'b1;
          end else begin
            ir    <= imem[pc[PC_W-1:0]][31:0];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa   <= rf[rs];
          opb   <= rf[rt];
          simm  <= {{(DATA_W-16){ir[15]}}, ir[15:0]};
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (!exec_ok) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_HALT;
          end else begin
            case (op)
              OP_BEQ: begin
                pc    <= (opa == opb) ? br_tgt : pc_inc;
                state <= S_FETCH;
              end
              OP_HALT: begin
                done  <= 1'b1;
                state <= S_HALT;
              end
              OP_LW, OP_SW: begin
                res   <= alu;
                state <= S_MEM;
              end
              default: begin
                res   <= alu;
                state <= S_WB;
              end
            endcase
          end
        end
        S_MEM: begin
          if (mem_bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_HALT;
          end else if (op == OP_SW) begin
            pc    <= pc_inc;
            state <= S_FETCH;
          end else begin
            res   <= dmem[mem_idx];
            state <= S_WB;
          end
        end
        S_WB: begin
          if (wb_dst != 5'd0) rf[wb_dst] <= res;
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memories are not reset. The sw store is gated by rst_n so an
  // instruction caught by reset never lands in dmem.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) begin
      if (!ld_sel && ({1'b0, ld_addr} < (LA_W+1)'(IMEM_DEPTH)))
        imem[ld_addr[PC_W-1:0]] <= ld_wdata;
      if (ld_sel && ({1'b0, ld_addr} < (LA_W+1)'(DMEM_DEPTH)))
        dmem[ld_addr[DA_W-1:0]] <= ld_wdata;
    end
    if (rst_n && state == S_MEM && op == OP_SW && !mem_bad)
      dmem[mem_idx] <= opb;
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: an instruction-level model produces the
// architectural effects and an expected per-cycle status trace (busy, done,
// err, retire, retire_pc) from per-class latencies; a negedge process
// checks the DUT against that trace, and register/dmem contents are
// compared through the debug ports after every run.
module tb_mips_multicycle_core;
  localparam int          IMD  = 16;
  localparam int          DMD  = 32;
  localparam logic [31:0] BASE = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_we, ld_sel;
  logic [4:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic [4:0]  prog_len;
  logic        start;
  logic        busy, done, err, retire;
  logic [3:0]  retire_pc;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic [4:0]  dbg_mem_addr;
  logic [31:0] dbg_mem_data;

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk(clk), .rst_n(rst_n),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .prog_len(prog_len), .start(start),
    .busy(busy), .done(done), .err(err),
    .retire(retire), .retire_pc(retire_pc),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data)
  );

  typedef struct packed {
    logic       busy, done, err, retire;
    logic [3:0] rpc;
  } cyc_t;

  cyc_t        exp_q[$];
  cyc_t        ce;
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [DMD];
  logic [31:0] m_im [IMD];
  logic [31:0] prog[$];
  int          n_vec = 0, n_miss = 0;
  bit          armed = 1'b0;
  int          cyc_n, done_n;
  int          ret_n[$], ret_pc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // ---------------- instruction-level model ----------------
  function automatic void push(input bit b, input bit d, input bit e, input bit r, input int pc);
    cyc_t c;
    c.busy = b; c.done = d; c.err = e; c.retire = r; c.rpc = pc[3:0];
    exp_q.push_back(c);
  endfunction

  function automatic void busy_n(input int n);
    for (int i = 0; i < n; i++) push(1, 0, 0, 0, 0);
  endfunction

  function automatic void halt_out(input bit e);
    push(0, 1, e, 0, 0);
    push(0, 1, e, 0, 0);
  endfunction

  function automatic void wr(input int r, input logic [31:0] v);
    if (r != 0) m_rf[r] = v;
  endfunction

  // Cycles per class, counting the FETCH cycle: R/addi 4, lw 5, sw 4,
  // beq/halt 3; the retire pulse is in the last of them. A faulting
  // instruction spends its cycles up to the faulting state, then HALT.
  function automatic void model_run(input int plen);
    int pc = 0, steps = 0, rs, rt, rd, idx;
    logic [31:0] ir, a, b, simm, ea, r;
    logic [5:0]  op, fn;
    bit ok;
    exp_q.delete();
    while (1) begin
      if (pc >= plen || pc >= IMD || steps > 100) begin
        push(1, 0, 0, 0, 0);
        halt_out(0);
        return;
      end
      steps++;
      ir = m_im[pc];
      op = ir[31:26]; fn = ir[5:0];
      rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
      a = m_rf[rs]; b = m_rf[rt];
      simm = {{16{ir[15]}}, ir[15:0]};
      r = 32'h0;
      case (op)
        6'h00: begin
          ok = 1;
          case (fn)
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ok = 0;
          endcase
          busy_n(3);
          if (!ok) begin halt_out(1); return; end
          push(1, 0, 0, 1, pc); wr(rd, r); pc++;
        end
        6'h08: begin
          busy_n(3); push(1, 0, 0, 1, pc); wr(rt, a + simm); pc++;
        end
        6'h23, 6'h2B: begin
          ea = a + simm;
          if (ea[1:0] != 2'b00 || ea < BASE || ea >= BASE + 4 * DMD) begin
            busy_n(4); halt_out(1); return;
          end
          idx = int'((ea - BASE) / 4);
          if (op == 6'h23) begin
            busy_n(4); push(1, 0, 0, 1, pc); wr(rt, m_dm[idx]);
          end else begin
            busy_n(3); push(1, 0, 0, 1, pc); m_dm[idx] = b;
          end
          pc++;
        end
        6'h04: begin
          busy_n(2); push(1, 0, 0, 1, pc);
          pc = (a == b) ? ((pc + 1 + int'($signed(simm))) & 31) : pc + 1;
        end
        6'h3F: begin
          busy_n(2); push(1, 0, 0, 1, pc); halt_out(0); return;
        end
        default: begin
          busy_n(3); halt_out(1); return;
        end
      endcase
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      if (retire) begin
        ret_n.push_back(cyc_n);
        ret_pc.push_back(int'(retire_pc));
      end
      if (done && done_n < 0) done_n = cyc_n;
      if (exp_q.size() > 0) begin
        ce = exp_q.pop_front();
        chk($sformatf("busy@%0d", cyc_n), busy, ce.busy);
        chk($sformatf("done@%0d", cyc_n), done, ce.done);
        chk($sformatf("err@%0d", cyc_n), err, ce.err);
        chk($sformatf("retire@%0d", cyc_n), retire, ce.retire);
        if (ce.retire) chk($sformatf("retire_pc@%0d", cyc_n), retire_pc, ce.rpc);
      end
      cyc_n++;
    end
  end

  // ---------------- drivers ----------------
  task automatic load(input bit sel, input int addr, input logic [31:0] d);
    @(posedge clk); #1;
    ld_we = 1; ld_sel = sel; ld_addr = addr[4:0]; ld_wdata = d;
    @(posedge clk); #1;
    ld_we = 0;
    if (!sel && addr < IMD) m_im[addr] = d;
    if (sel && addr < DMD) m_dm[addr] = d;
  endtask

  task automatic load_prog();
    foreach (prog[i]) load(0, i, prog[i]);
  endtask

  task automatic rdreg(input int r, output logic [31:0] v);
    dbg_reg_addr = r[4:0]; #1; v = dbg_reg_data;
  endtask

  task automatic check_arch(input string tag);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) begin
      rdreg(r, v);
      chk($sformatf("%s_reg%0d", tag, r), v, m_rf[r]);
    end
    for (int m = 0; m < DMD; m++) begin
      dbg_mem_addr = m[4:0]; #1;
      chk($sformatf("%s_dmem%0d", tag, m), dbg_mem_data, m_dm[m]);
    end
  endtask

  // poke: mid-run dmem load and start, both of which must be ignored
  task automatic run(input int plen, input bit poke, input string tag);
    @(posedge clk); #1;
    model_run(plen);
    ret_n.delete(); ret_pc.delete(); done_n = -1; cyc_n = 0;
    prog_len = plen[4:0]; start = 1;
    @(posedge clk); #1;
    start = 0; armed = 1;
    if (poke) begin
      @(posedge clk); #1;
      ld_we = 1; ld_sel = 1; ld_addr = 5'd5; ld_wdata = 32'hDEAD_BEEF; start = 1;
      @(posedge clk); #1;
      ld_we = 0; start = 0;
    end
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
    #1 armed = 0;
    if (exp_q.size() > 0) begin
      n_vec++; n_miss++;
      $display("FAIL %s_timeout: %0d trace cycles unconsumed, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    check_arch(tag);
  endtask

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'b0, rs[4:0], rt[4:0], rd[4:0], 5'b0, fn[5:0]};
  endfunction

  function automatic int src_reg();
    int s = $urandom_range(0, 8);
    return (s == 8) ? 0 : 8 + s;
  endfunction

  function automatic logic [31:0] rand_instr();
    int k = $urandom_range(0, 19);
    int dst = 8 + $urandom_range(0, 7);
    int off = 4 * $urandom_range(0, 33) + (($urandom_range(0, 9) == 0) ? 2 : 0);
    int fns[5] = '{32, 34, 36, 37, 42};
    int fn = ($urandom_range(0, 15) == 0) ? 7 : fns[$urandom_range(0, 4)];
    if (k < 5)       return enc_i(8, src_reg(), dst, $urandom_range(0, 65535));
    else if (k < 10) return enc_r(src_reg(), src_reg(), dst, fn);
    else if (k < 13) return enc_i(35, 16, dst, off);
    else if (k < 16) return enc_i(43, 16, src_reg(), off);
    else if (k < 18) return enc_i(4, src_reg(), src_reg(), $urandom_range(0, 3));
    else if (k == 18) return 32'hFC00_0000;
    else             return enc_i(3, 0, 0, 0);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int plen;
    rst_n = 0; ld_we = 0; ld_sel = 0; ld_addr = '0; ld_wdata = '0;
    prog_len = '0; start = 0; dbg_reg_addr = '0; dbg_mem_addr = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_retire", retire, 0);
    chk("rst_retire_pc", retire_pc, 0);
    rdreg(9, v); chk("rst_reg9", v, 0);
    rst_n = 1;

    for (int i = 0; i < DMD; i++) load(1, i, $urandom);

    // three ALU ops back to back
    prog = '{32'h20080004, 32'h2009000E, 32'h01095020};
    load_prog(); run(3, 0, "t1");
    rdreg(8, v);  chk("t1_r8", v, 4);
    rdreg(9, v);  chk("t1_r9", v, 14);
    rdreg(10, v); chk("t1_r10", v, 18);
    chk("t1_ret0", qat(ret_n, 0), 3);
    chk("t1_ret1", qat(ret_n, 1), 7);
    chk("t1_ret2", qat(ret_n, 2), 11);
    chk("t1_done_cyc", done_n, 13);

    // lw/sw against preloaded dmem, $10 carried over
    load(1, 1, 98);
    prog = '{32'h20104000, 32'h8E0B0004, 32'hAE0A0008};
    load_prog(); run(3, 0, "t2");
    rdreg(11, v); chk("t2_r11", v, 98);
    dbg_mem_addr = 5'd2; #1; chk("t2_dmem2", dbg_mem_data, 18);
    chk("t2_ret_lw", qat(ret_n, 1), 8);   // lw FETCH at cycle 4, retires in its 5th cycle
    chk("t2_ret_sw", qat(ret_n, 2), 12);

    // signed slt, then a write to $0
    prog = '{32'h200CFFFF, 32'h0180682A};
    load_prog(); run(2, 0, "t3");
    rdreg(12, v); chk("t3_r12", v, 32'hFFFF_FFFF);
    rdreg(13, v); chk("t3_r13", v, 1);
    prog = '{32'h20000007};
    load_prog(); run(1, 0, "t3b");
    rdreg(0, v); chk("t3b_r0", v, 0);

    // taken branch skips one instruction
    prog = '{32'h10000001, 32'h20080063, 32'h2008002A};
    load_prog(); run(3, 0, "t4");
    rdreg(8, v); chk("t4_r8", v, 42);
    chk("t4_nret", ret_pc.size(), 2);
    chk("t4_rpc0", qat(ret_pc, 0), 0);
    chk("t4_rpc1", qat(ret_pc, 1), 2);

    // misaligned and past-the-end loads
    prog = '{32'h20104000, 32'h8E0B0002};
    load_prog(); run(2, 0, "t5a");
    chk("t5a_err", err, 1); chk("t5a_done", done, 1);
    rdreg(11, v); chk("t5a_r11", v, 98);
    chk("t5a_nret", ret_n.size(), 1);
    prog = '{32'h20104000, 32'h8E0B0080};
    load_prog(); run(2, 0, "t5b");
    chk("t5b_err", err, 1);
    rdreg(11, v); chk("t5b_r11", v, 98);

    // branch target beyond prog_len halts cleanly
    prog = '{32'h1000000A, 32'h20080001, 32'h20080002};
    load_prog(); run(3, 0, "t6");
    chk("t6_err", err, 0); chk("t6_done", done, 1);
    chk("t6_nret", ret_n.size(), 1);

    // imem write beyond depth must not alias onto imem[4]
    prog = '{32'h20080001, 32'h20080002, 32'h20080003, 32'h20080004, 32'hFC000000};
    load_prog(); load(0, 20, 32'h0000_0000);
    run(5, 1, "t7");
    chk("t7_err", err, 0);

    // randomized programs
    for (int p = 0; p < 12; p++) begin
      prog = '{32'h20104000};
      plen = $urandom_range(3, 12);
      for (int i = 1; i < plen; i++) prog.push_back(rand_instr());
      load_prog();
      if ($urandom_range(0, 3) == 0) plen = $urandom_range(1, plen);
      run(plen, $urandom_range(0, 2) == 0, $sformatf("rnd%0d", p));
    end

    // reset while an sw sits in MEM
    load(1, 0, 32'h1111_2222);
    prog = '{32'h20104000, 32'h20080055, 32'hAE080000};
    load_prog();
    @(posedge clk); #1; prog_len = 5'd3; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (11) @(posedge clk);
    #1 rst_n = 0;
    #2 rst_n = 1;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    dbg_mem_addr = 5'd0; #1; chk("rstmid_dmem0", dbg_mem_data, 32'h1111_2222);
    check_arch("rstmid");

    prog = '{32'h20080004, 32'h2009000E, 32'h01095020};
    load_prog(); run(3, 0, "post");
    rdreg(10, v); chk("post_r10", v, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
